// File: rtl/mx_fp8_normalizer.sv
// Converts a signed fixed-point accumulator plus a shared block scale exponent into an OCP FP8 E4M3 byte.
// Three pipeline stages (magnitude/LZC, align, round/pack) advance together under a single stall signal.
module mx_fp8_normalizer #(
    parameter int ACC_W = 20,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] acc_in,
    input  logic [EXP_W-1:0] scale_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_sat
);
    localparam int P_W = $clog2(ACC_W);
    localparam int E_W = EXP_W + 2;

    localparam logic signed [E_W-1:0] E_MIN      = E_W'(-6);
    localparam logic signed [E_W-1:0] E_MAX      = E_W'(8);
    localparam logic signed [E_W-1:0] BIAS       = E_W'(7);
    localparam logic signed [E_W-1:0] SUB_OFF    = E_W'(9);
    localparam logic signed [E_W-1:0] MAX_BIASED = E_W'(15);

    logic advance;
    assign advance  = ~(out_valid & ~out_ready);
    assign in_ready = advance;

    // ---------------- stage 1: sign, magnitude, leading-one index
    logic [ACC_W-1:0] mag_c;
    logic [P_W-1:0]   lead_c;

    always_comb begin
        mag_c  = acc_in[ACC_W-1] ? -acc_in : acc_in;
        lead_c = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag_c[i]) lead_c = P_W'(i);
        end
    end

    logic             v1, sign1, zero1;
    logic [ACC_W-1:0] mag1;
    logic [P_W-1:0]   lead1;
    logic [EXP_W-1:0] scale1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            sign1  <= 1'b0;
            zero1  <= 1'b0;
            mag1   <= '0;
            lead1  <= '0;
            scale1 <= '0;
        end else if (advance) begin
            v1     <= in_valid;
            sign1  <= acc_in[ACC_W-1];
            zero1  <= (mag_c == '0);
            mag1   <= mag_c;
            lead1  <= lead_c;
            scale1 <= scale_exp;
        end
    end

    // ---------------- stage 2: exponent, mantissa/guard/sticky extraction
    logic signed [E_W-1:0] e_c;
    logic signed [E_W-1:0] sub_s_c;
    logic [E_W-1:0]        sub_r_c;
    logic [P_W-1:0]        lsh_c;
    logic [ACC_W-2:0]      norm_c;
    logic [ACC_W+2:0]      ext_c;
    logic                  normal_c, ovf_c, g_c, st_c;
    logic [2:0]            mant_c;

    always_comb begin
        e_c      = $signed({{(E_W-P_W){1'b0}}, lead1}) + $signed({{2{scale1[EXP_W-1]}}, scale1});
        normal_c = (e_c >= E_MIN);
        ovf_c    = (e_c > E_MAX);
        sub_s_c  = $signed({{2{scale1[EXP_W-1]}}, scale1}) + SUB_OFF;
        sub_r_c  = $unsigned(-sub_s_c);
        lsh_c    = P_W'(ACC_W - 1) - lead1;
        norm_c   = (ACC_W-1)'(mag1 << lsh_c);
        ext_c    = '0;
        mant_c   = '0;
        g_c      = 1'b0;
        st_c     = 1'b0;
        if (normal_c) begin
            // leading one sits just above the kept bits; lower bits zero-fill when lead1 < 4
            mant_c = norm_c[ACC_W-2 -: 3];
            g_c    = norm_c[ACC_W-5];
            st_c   = |norm_c[ACC_W-6:0];
        end else if (!sub_s_c[E_W-1]) begin
            mant_c = 3'(mag1 << sub_s_c[1:0]);
        end else if (sub_r_c > E_W'(ACC_W)) begin
            st_c = |mag1;
        end else begin
            ext_c  = (ACC_W+3)'({mag1, {ACC_W{1'b0}}} >> sub_r_c);
            mant_c = ext_c[ACC_W+2:ACC_W];
            g_c    = ext_c[ACC_W-1];
            st_c   = |ext_c[ACC_W-2:0];
        end
    end

    logic                  v2, sign2, zero2, normal2, ovf2, g2, st2;
    logic signed [E_W-1:0] e2;
    logic [2:0]            mant2;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2      <= 1'b0;
            sign2   <= 1'b0;
            zero2   <= 1'b0;
            normal2 <= 1'b0;
            ovf2    <= 1'b0;
            g2      <= 1'b0;
            st2     <= 1'b0;
            e2      <= '0;
            mant2   <= '0;
        end else if (advance) begin
            v2      <= v1;
            sign2   <= sign1;
            zero2   <= zero1;
            normal2 <= normal_c;
            ovf2    <= ovf_c;
            g2      <= g_c;
            st2     <= st_c;
            e2      <= e_c;
            mant2   <= mant_c;
        end
    end

    // ---------------- stage 3: round to nearest even, saturate, pack
    logic                  inc_c, sat_c;
    logic [3:0]            mant_r_c;
    logic signed [E_W-1:0] biased_c;
    logic [7:0]            data_c;

    always_comb begin
        inc_c    = g2 & (st2 | mant2[0]);
        mant_r_c = {1'b0, mant2} + {3'b000, inc_c};
        biased_c = e2 + BIAS + $signed({{(E_W-1){1'b0}}, mant_r_c[3]});
        sat_c    = 1'b0;
        data_c   = 8'h00;
        if (zero2) begin
            data_c = 8'h00;
        end else if (!normal2) begin
            // a rounded mantissa of 8 lands exactly on the min-normal code
            data_c = {sign2, 3'b000, mant_r_c};
        end else if (ovf2 || (biased_c > MAX_BIASED) ||
                     ((biased_c == MAX_BIASED) && (mant_r_c[2:0] == 3'b111))) begin
            sat_c  = 1'b1;
            data_c = {sign2, 7'h7E};
        end else begin
            data_c = {sign2, biased_c[3:0], mant_r_c[2:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sat   <= 1'b0;
        end else if (advance) begin
            out_valid <= v2;
            if (v2) begin
                out_data <= data_c;
                out_sat  <= sat_c;
            end
        end
    end

endmodule
